// File: rtl/r5fp_int2fp_pipe_pkg.sv
// Shared definitions for the integer-to-float converter: rounding-mode
// encodings, exception flag bit positions and the exponent bias helper.
package r5fp_int2fp_pipe_pkg;

  typedef enum logic [2:0] {
    RND_RNE = 3'd0,
    RND_RTZ = 3'd1,
    RND_RDN = 3'd2,
    RND_RUP = 3'd3,
    RND_RMM = 3'd4
  } rnd_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/r5fp_i2f_round.sv
// Combinational rounder: takes a normalized significand with guard/sticky
// and produces the packed {sign, exp, frac} result plus IEEE flags.
module r5fp_i2f_round
  import r5fp_int2fp_pipe_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8,
  parameter int E_W   = 6
) (
  input  logic               i_sign,
  input  logic [E_W-1:0]     i_e,
  input  logic [SIG_W:0]     i_mant,
  input  logic               i_g,
  input  logic               i_s,
  input  logic [2:0]         i_rnd,
  output logic [SIG_W+EXP_W:0] o_z,
  output logic [4:0]         o_flags
);

  localparam int BW = ((EXP_W > E_W) ? EXP_W : E_W) + 2;

  logic             w_inc;
  logic             w_to_inf;
  logic [SIG_W+1:0] w_sum;
  logic             w_carry;
  logic             w_unused_hidden;
  logic [BW-1:0]    w_biased;
  logic             w_of;
  logic             w_nx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_inc    = i_g && (i_s || i_mant[0]);
    w_to_inf = 1'b1;
    case (i_rnd)
      RND_RTZ: begin
        w_inc    = 1'b0;
        w_to_inf = 1'b0;
      end
      RND_RDN: begin
        w_inc    = i_sign && (i_g || i_s);
        w_to_inf = i_sign;
      end
      RND_RUP: begin
        w_inc    = !i_sign && (i_g || i_s);
        w_to_inf = !i_sign;
      end
      RND_RMM: w_inc = i_g;
      default: ;
    endcase
  end

  assign w_sum           = {1'b0, i_mant} + (SIG_W+2)'(w_inc);
  assign w_carry         = w_sum[SIG_W+1];
  assign w_unused_hidden = w_sum[SIG_W];
  assign w_biased        = BW'(i_e) + BW'(w_carry) + BW'(exp_bias(EXP_W));
  assign w_of            = (w_biased >= BW'((1 << EXP_W) - 1));
  assign w_nx            = i_g || i_s || w_of;

  // A carry leaves sum = 2^(SIG_W+1), so the fraction bits are already zero.
  always_comb begin
    o_z = {i_sign, w_biased[EXP_W-1:0], w_sum[SIG_W-1:0]};
    if (w_of) begin
      o_z = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}}
                     : {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};
    end
    o_flags          = '0;
    o_flags[FLAG_OF] = w_of;
    o_flags[FLAG_NX] = w_nx;
  end

endmodule

// File: rtl/r5fp_int2fp_pipe.sv
// Two-stage pipelined integer-to-float converter with valid/ready on both sides.
// Define R5FP_I2F_SKID_EN to add a 1-entry input skid buffer (registered in_ready).
module r5fp_int2fp_pipe
  import r5fp_int2fp_pipe_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8,
  parameter int INT_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_a,
  input  logic                   in_signed,
  input  logic                   in_half,
  input  logic [2:0]             in_rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_W+EXP_W:0]   out_z,
  output logic [4:0]             out_flags
);

  localparam int LZ_W = $clog2(INT_W + 1);
  localparam int E_W  = $clog2(INT_W);
  localparam int HALF = INT_W / 2;
  localparam int X_W  = INT_W + SIG_W + 2;

  function automatic logic [LZ_W-1:0] lzd_enc(input logic [INT_W-1:0] v);
    lzd_enc = LZ_W'(INT_W);
    for (int i = 0; i < INT_W; i++)
      if (v[i]) lzd_enc = LZ_W'(INT_W - 1 - i);
  endfunction

  logic               w_s1_adv, w_s2_adv;
  logic               r_s1_valid, r_s2_valid;
  logic               w_src_valid;
  logic [INT_W-1:0]   w_src_a;
  logic               w_src_signed, w_src_half;
  logic [2:0]         w_src_rnd;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

`ifdef R5FP_I2F_SKID_EN
  logic               r_skid_valid;
  logic [INT_W-1:0]   r_skid_a;
  logic               r_skid_signed, r_skid_half;
  logic [2:0]         r_skid_rnd;

  // Ready only depends on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready     = !r_skid_valid;
  assign w_src_valid  = r_skid_valid || in_valid;
  assign w_src_a      = r_skid_valid ? r_skid_a      : in_a;
  assign w_src_signed = r_skid_valid ? r_skid_signed : in_signed;
  assign w_src_half   = r_skid_valid ? r_skid_half   : in_half;
  assign w_src_rnd    = r_skid_valid ? r_skid_rnd    : in_rnd;

  always_ff @(posedge clk) begin
    if (reset)                          r_skid_valid <= 1'b0;
    else if (r_skid_valid && w_s1_adv)  r_skid_valid <= 1'b0;
    else if (!r_skid_valid && in_valid && !w_s1_adv) r_skid_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!r_skid_valid && in_valid && !w_s1_adv) begin
      r_skid_a      <= in_a;
      r_skid_signed <= in_signed;
      r_skid_half   <= in_half;
      r_skid_rnd    <= in_rnd;
    end
  end
`else
  assign in_ready     = w_s1_adv;
  assign w_src_valid  = in_valid;
  assign w_src_a      = in_a;
  assign w_src_signed = in_signed;
  assign w_src_half   = in_half;
  assign w_src_rnd    = in_rnd;
`endif

  // Stage 1: operand select, absolute value, normalization.
  logic [INT_W-1:0] w_op, w_abs, w_norm;
  logic             w_sign;
  logic [LZ_W-1:0]  w_lzc;
  logic [E_W-1:0]   w_e;

  assign w_op   = w_src_half ? {{HALF{w_src_signed & w_src_a[HALF-1]}}, w_src_a[HALF-1:0]}
                             : w_src_a;
  assign w_sign = w_src_signed && w_op[INT_W-1];
  assign w_abs  = w_sign ? -w_op : w_op;
  assign w_lzc  = lzd_enc(w_abs);
  assign w_norm = w_abs << w_lzc;
  assign w_e    = E_W'(INT_W - 1) - E_W'(w_lzc);

  logic             r_s1_sign, r_s1_zero;
  logic [E_W-1:0]   r_s1_e;
  logic [INT_W-1:0] r_s1_norm;
  logic [2:0]       r_s1_rnd;

  // NOTE: datapath registers are qualified by valid and need no reset; only control and outputs are reset.
  always_ff @(posedge clk) begin
    if (w_s1_adv && w_src_valid) begin
      r_s1_sign <= w_sign;
      r_s1_zero <= (w_abs == '0);
      r_s1_e    <= w_e;
      r_s1_norm <= w_norm;
      r_s1_rnd  <= w_src_rnd;
    end
  end

  // Stage 2: split mantissa/guard/sticky and round.
  logic [X_W-1:0]          w_x;
  logic [SIG_W+EXP_W:0]    w_rz, w_z;
  logic [4:0]              w_rflags, w_flags;

  assign w_x = {r_s1_norm, (SIG_W+2)'(0)};

  r5fp_i2f_round #(.SIG_W(SIG_W), .EXP_W(EXP_W), .E_W(E_W)) u_round (
    .i_sign  (r_s1_sign),
    .i_e     (r_s1_e),
    .i_mant  (w_x[X_W-1 -: SIG_W+1]),
    .i_g     (w_x[X_W-SIG_W-2]),
    .i_s     (|w_x[X_W-SIG_W-3:0]),
    .i_rnd   (r_s1_rnd),
    .o_z     (w_rz),
    .o_flags (w_rflags)
  );

  assign w_z     = r_s1_zero ? '0 : w_rz;
  assign w_flags = r_s1_zero ? '0 : w_rflags;

  logic [SIG_W+EXP_W:0] r_out_z;
  logic [4:0]           r_out_flags;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_z     <= '0;
      r_out_flags <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= w_src_valid;
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_z     <= w_z;
          r_out_flags <= w_flags;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_z     = r_out_z;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_r5fp_int2fp_pipe.sv
// Directed bench: single-precision and half-precision instances driven in lockstep,
// table-driven conversions plus backpressure and reset-during-stall sequences.
module tb_r5fp_int2fp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_a;
  logic        in_signed, in_half;
  logic [2:0]  in_rnd;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_z;
  logic [4:0]  out_flags;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_out_z;
  logic [4:0]  h_out_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r5fp_int2fp_pipe #(.SIG_W(23), .EXP_W(8), .INT_W(64)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_signed(in_signed), .in_half(in_half), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags)
  );

  r5fp_int2fp_pipe #(.SIG_W(10), .EXP_W(5), .INT_W(64)) u_hdut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_a(in_a), .in_signed(in_signed), .in_half(in_half), .in_rnd(in_rnd),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_z(h_out_z), .out_flags(h_out_flags)
  );

  typedef struct {
    logic [63:0] a;
    logic        sgn;
    logic        half;
    logic [2:0]  rnd;
    logic        hp;
    logic [31:0] z;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [63:0] a, input logic sgn, input logic half,
                     input logic [2:0] rnd, input logic hp, input logic [31:0] z,
                     input logic [4:0] flags);
    vec_t v;
    v.a = a; v.sgn = sgn; v.half = half; v.rnd = rnd; v.hp = hp; v.z = z; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = v.a; in_signed = v.sgn; in_half = v.half; in_rnd = v.rnd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), 64'(lat), 64'd2);
    if (v.hp) begin
      check($sformatf("vec%0d hp z", idx), 64'(h_out_z), 64'(v.z[15:0]));
      check($sformatf("vec%0d hp flags", idx), 64'(h_out_flags), 64'(v.flags));
    end else begin
      check($sformatf("vec%0d z", idx), 64'(out_z), 64'(v.z));
      check($sformatf("vec%0d flags", idx), 64'(out_flags), 64'(v.flags));
    end
  endtask

  logic [31:0] bp_exp [4];
  int          idx, rx, acc;
  logic        txd, rxd;

  initial begin
    // {a, signed, half, rnd, hp, z, flags}; rnd: 0 RNE 1 RTZ 2 RDN 3 RUP 4 RMM
    add(64'h0,                   1, 0, 3'd0, 0, 32'h00000000, 5'h00);
    add(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 3'd0, 0, 32'hBF800000, 5'h00);
    add(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'd0, 0, 32'h5F800000, 5'h01);
    add(64'h0000_0000_0100_0001, 0, 0, 3'd0, 0, 32'h4B800000, 5'h01);
    add(64'h0000_0000_0100_0001, 0, 0, 3'd3, 0, 32'h4B800001, 5'h01);
    add(64'h0000_0000_0100_0001, 0, 0, 3'd1, 0, 32'h4B800000, 5'h01);
    add(64'h0000_0000_0100_0001, 0, 0, 3'd4, 0, 32'h4B800001, 5'h01);
    add(64'h0000_0000_0100_0003, 0, 0, 3'd0, 0, 32'h4B800002, 5'h01);
    add(64'h0000_0000_0100_0003, 0, 0, 3'd5, 0, 32'h4B800002, 5'h01);
    add(64'h0000_0000_0100_0001, 0, 0, 3'd7, 0, 32'h4B800000, 5'h01);
    add(64'hFFFF_FFFF_FEFF_FFFF,  1, 0, 3'd2, 0, 32'hCB800001, 5'h01);
    add(64'hFFFF_FFFF_8000_0000, 1, 1, 3'd0, 0, 32'hCF000000, 5'h00);
    add(64'h8000_0000_0000_0000, 1, 0, 3'd0, 0, 32'hDF000000, 5'h00);
    add(64'h1,                   0, 0, 3'd0, 0, 32'h3F800000, 5'h00);
    add(64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 3'd2, 0, 32'hC0400000, 5'h00);
    add(64'h0000_0000_FFFF_FF80, 0, 0, 3'd0, 0, 32'h4F800000, 5'h01);
    add(64'h0,                   0, 0, 3'd3, 0, 32'h00000000, 5'h00);
    add(64'h1234_5678_FFFF_FFFF, 0, 1, 3'd0, 0, 32'h4F800000, 5'h01);
    add(64'h1234_5678_FFFF_FFFF, 0, 1, 3'd1, 0, 32'h4F7FFFFF, 5'h01);
    add(64'h0000_0000_0001_0000, 0, 0, 3'd0, 1, 32'h00007C00, 5'h05);
    add(64'h0000_0000_0001_0000, 0, 0, 3'd1, 1, 32'h00007BFF, 5'h05);
    add(64'hFFFF_FFFF_FFFF_0000, 1, 0, 3'd3, 1, 32'h0000FBFF, 5'h05);
    add(64'hFFFF_FFFF_FFFF_0000, 1, 0, 3'd2, 1, 32'h0000FC00, 5'h05);
    add(64'h0000_0000_0000_FFE0, 0, 0, 3'd0, 1, 32'h00007BFF, 5'h00);
    add(64'h0000_0000_0000_FFF0, 0, 0, 3'd0, 1, 32'h00007C00, 5'h05);
    add(64'h0000_0000_0000_FFEF, 0, 0, 3'd0, 1, 32'h00007BFF, 5'h01);
    add(64'h1,                   0, 0, 3'd0, 1, 32'h00003C00, 5'h00);

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_signed = 1'b0; in_half = 1'b0;
    in_rnd = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_z", 64'(out_z), 64'd0);
    check("reset out_flags", 64'(out_flags), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: four back-to-back offers, consumer stalled for 5 cycles.
    bp_exp[0] = 32'h3F800000; bp_exp[1] = 32'h40000000;
    bp_exp[2] = 32'h40400000; bp_exp[3] = 32'h40800000;
    idx = 0; rx = 0; acc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 64'd1;
    in_signed = 1'b0; in_half = 1'b0; in_rnd = 3'd0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      txd = in_valid && in_ready;
      rxd = out_valid && out_ready;
      if (txd) acc++;
      if (rxd) begin
        check($sformatf("bp result %0d", rx), 64'(out_z), 64'(bp_exp[rx]));
        rx++;
      end
      if (cyc == 2 || cyc == 4) begin
        check($sformatf("bp stall valid c%0d", cyc), 64'(out_valid), 64'd1);
        check($sformatf("bp stall z c%0d", cyc), 64'(out_z), 64'(bp_exp[0]));
        check($sformatf("bp stall flags c%0d", cyc), 64'(out_flags), 64'd0);
      end
      if (cyc == 4) check("bp accepted during stall", 64'(acc), 64'd2);
      @(posedge clk); #1;
      if (txd) idx++;
      in_valid  = (idx < 4);
      in_a      = 64'(idx + 1);
      out_ready = (cyc >= 4);
    end
    check("bp all results drained", 64'(rx), 64'd4);
    in_valid = 1'b0;

    // Reset while a result is stalled at the output.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 64'd5;
    @(posedge clk); #1;
    in_a = 64'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stall before reset valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid-stall reset out_valid", 64'(out_valid), 64'd0);
    check("mid-stall reset out_z", 64'(out_z), 64'd0);
    check("mid-stall reset out_flags", 64'(out_flags), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("discarded after reset", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
